// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces whole
//   scan frames, and turns each clean single-key press into a 4-bit code
//   (row*4+col). Codes are queued in a small FIFO with a valid/ready handshake,
//   and the last eight codes are kept in a 32-bit entry register for display.
//
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   row_i[3:0]   keypad rows, active-low, asynchronous to clk
//   col_o[3:0]   keypad column drive, active-low, one-cold
//   key_valid_o  FIFO not empty
//   key_code_o   FIFO head code
//   key_ready_i  consumer accepts the head while key_valid_o is high
//   clear_i      synchronous flush of FIFO, overflow flag and entry register
//   overflow_o   sticky: a key event was dropped because the FIFO was full
//   entry_o      last eight codes, newest in [3:0]
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o,
  input  logic        key_ready_i,
  input  logic        clear_i,
  output logic        overflow_o,
  output logic [31:0] entry_o
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

  // row synchronizer; idles high (no key) out of reset
  logic [3:0] row_s1, row_s2;

  // scan / debounce state
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      frame_map;
  logic [15:0]      prev_frame;
  logic [15:0]      stable_map;
  logic [CNT_W-1:0] stable_cnt;

  logic             tc;
  logic             frame_done;
  logic [15:0]      frame_next;
  logic [CNT_W-1:0] cnt_next;
  logic             load_stable;
  logic             new_onehot;
  logic [3:0]       new_code;
  logic             event_set;

  // event stage between stable_map update and FIFO write
  logic             evt_pending;
  logic [3:0]       evt_code;

  // FIFO
  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop, drop;

  assign tc         = (div_cnt == DIV_LAST);
  assign frame_done = tc && (col_idx == 2'd3);
  assign col_o      = ~(4'b0001 << col_idx);

  // frame map as it will look after this cycle's row sample
  always_comb begin
    logic [3:0] idx;
    frame_next = frame_map;
    for (int unsigned r = 0; r < 4; r++) begin
      idx = {2'(r), col_idx};
      frame_next[idx] = ~row_s2[r];
    end
  end

  always_comb begin
    cnt_next = CNT_W'(1);
    if (frame_next == prev_frame) begin
      cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
    end
  end

  assign load_stable = frame_done && (cnt_next == CNT_MAX);
  assign new_onehot  = (frame_next != '0) && ((frame_next & (frame_next - 16'd1)) == '0);

  always_comb begin
    new_code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (frame_next[i]) new_code = 4'(i);
    end
  end

  // only an all-released -> single-key transition is a press; holds and
  // multi-key maps never qualify
  assign event_set = load_stable && (stable_map == '0) && new_onehot;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_s1      <= '1;
      row_s2      <= '1;
      div_cnt     <= '0;
      col_idx     <= '0;
      frame_map   <= '0;
      prev_frame  <= '0;
      stable_map  <= '0;
      stable_cnt  <= '0;
      evt_pending <= 1'b0;
      evt_code    <= '0;
    end else begin
      row_s1      <= row_i;
      row_s2      <= row_s1;
      evt_pending <= event_set;
      evt_code    <= new_code;
      if (tc) begin
        div_cnt   <= '0;
        col_idx   <= col_idx + 2'd1;
        frame_map <= frame_next;
        if (frame_done) begin
          prev_frame <= frame_next;
          stable_cnt <= cnt_next;
          if (load_stable) stable_map <= frame_next;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign pop  = !fifo_empty && key_ready_i && !clear_i;
  assign push = evt_pending && !clear_i && (!fifo_full || pop);
  assign drop = evt_pending && !clear_i && fifo_full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
      entry_o    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clear_i) begin
      rd_ptr     <= wr_ptr;
      overflow_o <= 1'b0;
      entry_o    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= evt_code;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)         rd_ptr     <= rd_ptr + 1'b1;
      if (drop)        overflow_o <= 1'b1;
      if (evt_pending) entry_o    <= {entry_o[27:0], evt_code};
    end
  end

  assign key_valid_o = !fifo_empty;
  assign key_code_o  = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3,
//   FIFO_DEPTH=4 (frame = 16 cycles). A small keypad model drives row_i from
//   the pressed-key set and col_o. Key changes are applied right after a frame
//   boundary so the push edge is known: frame end + 48 cycles is the
//   stable_map update, +49 the FIFO write.
module tb_keypad_scanner;

  localparam int unsigned FRAME = 16;

  logic        clk;
  logic        rstn;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic        key_ready_i;
  logic        clear_i;
  logic        overflow_o;
  logic [31:0] entry_o;

  logic [15:0] keys;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_fail;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .key_ready_i (key_ready_i),
    .clear_i     (clear_i),
    .overflow_o  (overflow_o),
    .entry_o     (entry_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  // cycles since reset release; frame boundaries are multiples of FRAME
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic goto(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic frame_start();
    goto((cyc / FRAME + 1) * FRAME);
  endtask

  task automatic pop_one();
    key_ready_i = 1'b1;
    @(negedge clk);
    key_ready_i = 1'b0;
  endtask

  // press a key for 4 frames, release for 4 frames
  task automatic press(input int unsigned code);
    int unsigned p;
    frame_start();
    p = cyc;
    keys = '0;
    keys[code] = 1'b1;
    goto(p + 4*FRAME);
    keys = '0;
    goto(p + 8*FRAME);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p;
    logic [3:0] exp_codes [4];
    n_checks    = 0;
    n_fail      = 0;
    keys        = '0;
    key_ready_i = 1'b0;
    clear_i     = 1'b0;
    rstn        = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_col",   32'(col_o),       32'hE);
    check("rst_valid", 32'(key_valid_o), 32'h0);
    check("rst_code",  32'(key_code_o),  32'h0);
    check("rst_ovf",   32'(overflow_o),  32'h0);
    check("rst_entry", entry_o,          32'h0);
    rstn = 1'b1;

    // single press of key 6 (row 1, col 2), exact latency, no auto-repeat
    frame_start();
    p = cyc;
    keys[6] = 1'b1;
    goto(p + 48);
    check("s_early", 32'(key_valid_o), 32'h0);
    goto(p + 49);
    check("s_valid", 32'(key_valid_o), 32'h1);
    check("s_code",  32'(key_code_o),  32'h6);
    check("s_entry", entry_o,          32'h6);
    goto(p + 10*FRAME);
    check("s_hold",  entry_o,          32'h6);
    keys = '0;
    goto(p + 14*FRAME);
    pop_one();
    check("s_pop",   32'(key_valid_o), 32'h0);

    // bounce: key 6 toggled every frame never settles
    for (int i = 0; i < 10; i++) begin
      frame_start();
      keys[6] = ~keys[6];
    end
    frame_start();
    goto(cyc + 2*FRAME);
    check("b_valid", 32'(key_valid_o), 32'h0);
    check("b_entry", entry_o,          32'h6);
    press(6);
    check("b_code",  32'(key_code_o),  32'h6);
    check("b_entry2", entry_o,         32'h66);
    pop_one();

    // multi-key: 0+5, then 0 alone, then released, then F
    frame_start();
    p = cyc;
    keys = 16'h0021;
    goto(p + 5*FRAME);
    check("m_two",   32'(key_valid_o), 32'h0);
    keys = 16'h0001;
    goto(p + 10*FRAME);
    check("m_one",   32'(key_valid_o), 32'h0);
    keys = '0;
    goto(p + 15*FRAME);
    press(15);
    check("m_code",  32'(key_code_o),  32'hF);
    check("m_entry", entry_o,          32'h66F);
    pop_one();
    check("m_pop",   32'(key_valid_o), 32'h0);

    // clear, then overflow with five presses into a 4-deep FIFO
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("c_entry", entry_o,          32'h0);
    check("c_ovf",   32'(overflow_o),  32'h0);
    for (int unsigned k = 1; k <= 5; k++) press(k);
    check("o_valid", 32'(key_valid_o), 32'h1);
    check("o_ovf",   32'(overflow_o),  32'h1);
    check("o_entry", entry_o,          32'h00012345);
    for (int unsigned k = 1; k <= 4; k++) begin
      check("o_drain", 32'(key_code_o), 32'(k));
      pop_one();
    end
    check("o_empty", 32'(key_valid_o), 32'h0);

    // clear in the same cycle as the push of key 9
    frame_start();
    p = cyc;
    keys[9] = 1'b1;
    goto(p + 48);
    clear_i = 1'b1;
    goto(p + 49);
    clear_i = 1'b0;
    check("ce_entry", entry_o,          32'h0);
    check("ce_ovf",   32'(overflow_o),  32'h0);
    check("ce_valid", 32'(key_valid_o), 32'h0);
    goto(p + 4*FRAME);
    keys = '0;
    goto(p + 8*FRAME);
    check("ce_after", 32'(key_valid_o), 32'h0);

    // full FIFO: push of C coincides with a pop
    press(7);
    press(8);
    press(10);
    press(11);
    check("f_head",  32'(key_code_o),  32'h7);
    frame_start();
    p = cyc;
    keys[12] = 1'b1;
    goto(p + 48);
    key_ready_i = 1'b1;
    goto(p + 49);
    key_ready_i = 1'b0;
    check("f_ovf",   32'(overflow_o),  32'h0);
    check("f_code",  32'(key_code_o),  32'h8);
    check("f_entry", entry_o,          32'h00078ABC);
    goto(p + 4*FRAME);
    keys = '0;
    goto(p + 8*FRAME);
    exp_codes[0] = 4'h8;
    exp_codes[1] = 4'hA;
    exp_codes[2] = 4'hB;
    exp_codes[3] = 4'hC;
    for (int k = 0; k < 4; k++) begin
      check("f_drain", 32'(key_code_o), 32'(exp_codes[k]));
      pop_one();
    end
    check("f_empty", 32'(key_valid_o), 32'h0);

    // reset mid-operation: 2 entries queued, key 3 held, column 3 driven
    press(1);
    press(2);
    frame_start();
    keys[3] = 1'b1;
    goto(cyc + 2*FRAME);
    for (int i = 0; i < 20 && col_o != 4'b0111; i++) @(negedge clk);
    check("r_col3",  32'(col_o),       32'h7);
    rstn = 1'b0;
    #1;
    check("r_col",   32'(col_o),       32'hE);
    check("r_valid", 32'(key_valid_o), 32'h0);
    check("r_code",  32'(key_code_o),  32'h0);
    check("r_ovf",   32'(overflow_o),  32'h0);
    check("r_entry", entry_o,          32'h0);
    @(negedge clk);
    rstn = 1'b1;
    goto(48);
    check("r_early", 32'(key_valid_o), 32'h0);
    goto(49);
    check("r_valid2", 32'(key_valid_o), 32'h1);
    check("r_code2",  32'(key_code_o),  32'h3);
    check("r_entry2", entry_o,          32'h3);
    goto(300);
    check("r_hold",   entry_o,          32'h3);
    keys = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
